fp16_div_seq: RTL and testbench

Iterative FP16 (IEEE-754 binary16) divider, the inverse operation to the multiply path of the FP16 MAC unit.
- Computes q = a / b with a valid/ready handshake on both sides.
- Fills the gap left by the combinational add/multiply datapath, which cannot divide.
- Sits beside FP16adder; feeds normalisation and scaling steps of the MAC pipeline.

---
 rtl/fp16_pkg.sv | 33 +++
 rtl/fp16_div_core.sv | 50 +++++
 rtl/fp16_div_seq.sv | 142 ++++++++++++++
 tb/tb_fp16_div_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, divider FSM state type and operand classification.
package fp16_pkg;

  localparam int          EXP_BIAS  = 15;
  localparam int          EXP_MAX   = 31;
  localparam int          DIV_STEPS = 13;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPECIAL,
    ST_DIV,
    ST_NORM,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Subnormals report as zero so the datapath only ever sees 1.m significands.
  function automatic fp_class_t classify(input logic [15:0] x);
    fp_class_t c;
    c.is_nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    c.is_inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    c.is_zero = (x[14:10] == 5'h00);
    return c;
  endfunction

endpackage

// File: rtl/fp16_div_core.sv
// 13-step restoring divider on 11-bit significands 1.ma / 1.mb, one quotient bit per cycle.
module fp16_div_core
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  ma,
  input  logic [9:0]  mb,
  output logic        busy,
  output logic        done,
  output logic [12:0] quotient,
  output logic        sticky
);

  logic [11:0] rem_q;
  logic [10:0] div_q;
  logic [3:0]  cnt_q;
  logic [12:0] trial;
  logic        q_bit;

  assign trial  = {1'b0, rem_q} - {2'b00, div_q};
  assign q_bit  = ~trial[12];
  // done marks the cycle whose edge retires the last quotient bit.
  assign done   = busy && (cnt_q == 4'(DIV_STEPS - 1));
  assign sticky = (rem_q != 12'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt_q    <= 4'd0;
      rem_q    <= 12'd0;
      div_q    <= 11'd0;
      quotient <= 13'd0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt_q    <= 4'd0;
      rem_q    <= {1'b0, 1'b1, ma};
      div_q    <= {1'b1, mb};
      quotient <= 13'd0;
    end else if (busy) begin
      // After a restore the remainder is below the divisor, so bit 11 is always clear.
      quotient <= {quotient[11:0], q_bit};
      rem_q    <= q_bit ? {trial[10:0], 1'b0} : {rem_q[10:0], 1'b0};
      cnt_q    <= cnt_q + 4'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp16_div_seq.sv
// Iterative FP16 divider q = a / b with valid/ready on both sides, one operation in flight.
// Build option FP16_DIV_RNE_EN selects round-to-nearest-even; default truncates toward zero.
module fp16_div_seq
  import fp16_pkg::*;
#(
  parameter logic [15:0] CANON_NAN = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  // Handshake: a transfer happens on an edge where valid && ready; in_ready only in IDLE,
  // out_valid only in HOLD, and result/flags do not change while out_valid is high.
  state_t      state, state_nxt;
  logic [14:0] a_q, b_q;
  logic        sign_q;
  fp_class_t   ca_in, cb_in, ca, cb;
  logic        accept, special_in;
  logic        core_start, core_busy, core_done, core_sticky;
  logic [12:0] core_q;
  logic [15:0] inf_signed, spec_res, norm_res;
  logic [3:0]  spec_flags, norm_flags;
  logic        norm_shift, guard, stk, round_up;
  logic [6:0]  exp_raw, exp_norm, exp_fin;
  logic [9:0]  mant_trunc;
  logic [10:0] mant_sum;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_HOLD);
  assign accept     = in_valid && in_ready;
  assign ca_in      = classify(a);
  assign cb_in      = classify(b);
  assign special_in = |{ca_in, cb_in};
  assign core_start = accept && !special_in;
  assign ca         = classify({1'b0, a_q});
  assign cb         = classify({1'b0, b_q});
  assign inf_signed = sign_q ? FP16_NINF : FP16_PINF;

  fp16_div_core u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (core_start),
    .ma       (a[9:0]),
    .mb       (b[9:0]),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (core_q),
    .sticky   (core_sticky)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = special_in ? ST_SPECIAL : ST_DIV;
      ST_SPECIAL: state_nxt = ST_HOLD;
      ST_DIV:     if (core_done || !core_busy) state_nxt = ST_NORM;
      ST_NORM:    state_nxt = ST_HOLD;
      ST_HOLD:    if (out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    spec_res   = {sign_q, 15'd0};
    spec_flags = 4'b0000;
    if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      spec_res   = CANON_NAN;
      spec_flags = 4'b1000;
    end else if (ca.is_inf) begin
      spec_res = inf_signed;
    end else if (cb.is_zero) begin
      spec_res   = inf_signed;
      spec_flags = 4'b0100;
    end
  end

  always_comb begin
    norm_shift = ~core_q[12];
    exp_raw    = {2'b00, a_q[14:10]} - {2'b00, b_q[14:10]} + 7'(EXP_BIAS);
    exp_norm   = exp_raw - {6'd0, norm_shift};
    mant_trunc = norm_shift ? core_q[10:1] : core_q[11:2];
    guard      = norm_shift ? core_q[0] : core_q[1];
    stk        = norm_shift ? core_sticky : (core_q[0] | core_sticky);
`ifdef FP16_DIV_RNE_EN
    round_up   = guard && (stk || mant_trunc[0]);
`else
    round_up   = 1'b0;
`endif
    mant_sum   = {1'b0, mant_trunc} + {10'd0, round_up};
    // A rounding carry leaves mant_sum[9:0] at zero; it only bumps the exponent.
    exp_fin    = exp_norm + {6'd0, mant_sum[10]};
    norm_res   = {sign_q, exp_fin[4:0], mant_sum[9:0]};
    norm_flags = 4'b0000;
    if ($signed(exp_fin) >= $signed(7'(EXP_MAX))) begin
      norm_res   = inf_signed;
      norm_flags = 4'b0010;
    end else if ($signed(exp_fin) <= $signed(7'd0)) begin
      norm_res   = {sign_q, 15'd0};
      norm_flags = 4'b0001;
    end
  end

`ifndef FP16_DIV_RNE_EN
  logic unused_rnd;
  assign unused_rnd = guard ^ stk;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_q    <= 15'd0;
      b_q    <= 15'd0;
      sign_q <= 1'b0;
      result <= 16'h0000;
      flags  <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q    <= a[14:0];
        b_q    <= b[14:0];
        sign_q <= a[15] ^ b[15];
      end
      if (state == ST_SPECIAL) begin
        result <= spec_res;
        flags  <= spec_flags;
      end
      if (state == ST_NORM) begin
        result <= norm_res;
        flags  <= norm_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: directed plan cases, reset abort and randomized operands vs an
// exact integer-division reference model.
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready, out_valid;
  logic [15:0] result;
  logic [3:0]  flags;

  int          total = 0;
  int          bad = 0;
  logic [19:0] exp_q[$];

  fp16_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: quotient of exact significands scaled into [1024,2048) by integer division.
  function automatic logic [19:0] ref_div(input logic [15:0] x, input logic [15:0] y,
                                          output bit special);
    int ex, ey, mx, my, e, q, r;
    bit s, xn, xi, xz, yn, yi, yz;
    logic [15:0] res;
    logic [3:0]  f;
    logic [4:0]  e5;
    logic [9:0]  m10;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    xn = (ex == 31) && (x[9:0] != 0);
    xi = (ex == 31) && (x[9:0] == 0);
    xz = (ex == 0);
    yn = (ey == 31) && (y[9:0] != 0);
    yi = (ey == 31) && (y[9:0] == 0);
    yz = (ey == 0);
    special = xn || xi || xz || yn || yi || yz;
    f   = 4'b0000;
    res = {s, 15'h0000};
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      res = 16'h7E00;
      f   = 4'b1000;
    end else if (xi) begin
      res = {s, 15'h7C00};
    end else if (yz) begin
      res = {s, 15'h7C00};
      f   = 4'b0100;
    end else if (!(xz || yi)) begin
      mx = 1024 + int'(x[9:0]);
      my = 1024 + int'(y[9:0]);
      e  = ex - ey + 15;
      if (mx >= my) begin
        q = (mx * 1024) / my;
        r = (mx * 1024) % my;
      end else begin
        q = (mx * 2048) / my;
        r = (mx * 2048) % my;
        e = e - 1;
      end
`ifdef FP16_DIV_RNE_EN
      if ((2 * r > my) || ((2 * r == my) && (q % 2 == 1))) q = q + 1;
`else
      r = 0;
`endif
      if (q == 2048) begin
        q = 1024;
        e = e + 1;
      end
      if (e >= 31) begin
        res = {s, 15'h7C00};
        f   = 4'b0010;
      end else if (e <= 0) begin
        f = 4'b0001;
      end else begin
        e5  = 5'(e);
        m10 = 10'(q - 1024);
        res = {s, e5, m10};
      end
    end
    return {f, res};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = $urandom_range(0, 15);
    if (k == 0) v[14:10] = 5'd0;
    else if (k == 1) v[14:10] = 5'd31;
    else if (k == 2) begin
      v[14:10] = 5'd31;
      v[9:0]   = 10'd0;
    end else v[14:10] = 5'($urandom_range(1, 30));
    return v;
  endfunction

  // Drives one operation, checks latency, hold stability, result and release handshake.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input int hold);
    logic [19:0] e;
    bit sp;
    int lat, want_lat;
    e = ref_div(ta, tbv, sp);
    want_lat = sp ? 2 : 15;
    exp_q.push_back(e);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency %h/%h", ta, tbv), 32'(lat), 32'(want_lat));
    for (int i = 0; i < hold; i++) begin
      check("hold_result", 32'({flags, result}), 32'(exp_q[0]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    check($sformatf("result %h/%h", ta, tbv), 32'({flags, result}), 32'(exp_q.pop_front()));
    @(negedge clk);
    out_ready = 1'b0;
    check("no_accept_in_hold", 32'(in_ready), 32'd1);
    check("out_valid_drop", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] da[10];
    logic [15:0] db[10];
    bit seen;
    da = '{16'h3C00, 16'h4600, 16'hC000, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h0000, 16'h7E00, 16'h3C00, 16'h7BFF};
    db = '{16'h4000, 16'h4200, 16'h4000, 16'h4200, 16'h4C00,
           16'h0000, 16'h0000, 16'h3C00, 16'h7C00, 16'h1400};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'h0000);
    check("reset_flags", 32'(flags), 32'h0);

    run_op(16'h3C00, 16'h4000, 5);
    check("plan_half", 32'(ref_div(16'h3C00, 16'h4000, seen)), 32'h03800);
    for (int i = 1; i < 10; i++) run_op(da[i], db[i], 0);
    run_op(16'h0400, 16'h7BFF, 1);

    // Reset in the middle of a division must drop it silently.
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4200;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", 32'(result), 32'h0000);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    run_op(16'h4600, 16'h4200, 0);

    for (int i = 0; i < 40; i++) run_op(rand_fp(), rand_fp(), $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
